// File: rtl/decode_pkg.sv
// Shared types and default geometry for the instruction-decode stage.
// Field offsets are derived from the widths so the layout is defined in one place.
package decode_pkg;

    localparam int DEF_INSTR_W  = 32;
    localparam int DEF_OPCODE_W = 5;
    localparam int DEF_REG_W    = 5;
    localparam int DEF_IMM_W    = 12;
    localparam int DEF_XLEN     = 32;
    localparam int DEF_COUNT_W  = 32;

    // Word layout from LSB upward: opcode, rd, rs, rt, imm (idx 0..3 above opcode).
    function automatic int field_lsb(input int opcode_w, input int reg_w, input int idx);
        return opcode_w + idx * reg_w;
    endfunction

    localparam int DEF_RD_LSB  = field_lsb(DEF_OPCODE_W, DEF_REG_W, 0);
    localparam int DEF_RS_LSB  = field_lsb(DEF_OPCODE_W, DEF_REG_W, 1);
    localparam int DEF_RT_LSB  = field_lsb(DEF_OPCODE_W, DEF_REG_W, 2);
    localparam int DEF_IMM_LSB = field_lsb(DEF_OPCODE_W, DEF_REG_W, 3);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_OPCODE_W-1:0] opcode;
        logic [DEF_REG_W-1:0]    rd;
        logic [DEF_REG_W-1:0]    rs;
        logic [DEF_REG_W-1:0]    rt;
        logic [DEF_XLEN-1:0]     imm;
        logic                    illegal;
    } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch (master) and the decode stage (slave),
// including the decoded output fields and the throughput counter.
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int REG_W    = DEF_REG_W,
    parameter int XLEN     = DEF_XLEN,
    parameter int COUNT_W  = DEF_COUNT_W
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] out_opcode;
    logic [REG_W-1:0]    out_rd;
    logic [REG_W-1:0]    out_rs;
    logic [REG_W-1:0]    out_rt;
    logic [XLEN-1:0]     out_imm;
    logic                out_illegal;
    logic [COUNT_W-1:0]  decode_count;

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_imm, out_illegal, decode_count
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_imm, out_illegal, decode_count
    );
endinterface

// File: rtl/instr_field_split.sv
// Combinational split of an instruction word into fields, immediate
// extension (sign or zero per opcode) and the opcode legality flag.
module instr_field_split
    import decode_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int REG_W    = DEF_REG_W,
    parameter int IMM_W    = DEF_IMM_W,
    parameter int XLEN     = DEF_XLEN,
    parameter logic [2**OPCODE_W-1:0] LEGAL_MASK = 32'h3FFF_FFFF,
    parameter logic [2**OPCODE_W-1:0] ZEXT_MASK  = 32'h0000_0F00
)
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [XLEN-1:0]     imm,
    output logic                illegal
);
    localparam int IMM_LSB = field_lsb(OPCODE_W, REG_W, 3);

    logic [REG_W-1:0] reg_fields [3];
    logic [IMM_W-1:0] imm_raw;
    logic             imm_fill;

    assign opcode  = instr[OPCODE_W-1:0];
    assign imm_raw = instr[IMM_LSB +: IMM_W];

    // Register fields stacked directly above the opcode: rd, rs, rt.
    for (genvar gi = 0; gi < 3; gi++) begin : g_reg_field
        assign reg_fields[gi] = instr[field_lsb(OPCODE_W, REG_W, gi) +: REG_W];
    end

    assign rd = reg_fields[0];
    assign rs = reg_fields[1];
    assign rt = reg_fields[2];

    assign imm_fill = ZEXT_MASK[opcode] ? 1'b0 : imm_raw[IMM_W-1];
    assign illegal  = ~LEGAL_MASK[opcode];

    if (XLEN > IMM_W) begin : g_extend
        assign imm = {{(XLEN-IMM_W){imm_fill}}, imm_raw};
    end else begin : g_no_extend
        logic unused_fill;
        assign unused_fill = imm_fill;
        assign imm         = imm_raw;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on entry, buffers in an OUT + SKID pair
// behind a registered in_ready, and counts completed output handshakes.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int REG_W    = DEF_REG_W,
    parameter int IMM_W    = DEF_IMM_W,
    parameter int XLEN     = DEF_XLEN,
    parameter logic [2**OPCODE_W-1:0] LEGAL_MASK = 32'h3FFF_FFFF,
    parameter logic [2**OPCODE_W-1:0] ZEXT_MASK  = 32'h0000_0F00,
    parameter int COUNT_W  = DEF_COUNT_W
)
(
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    if (OPCODE_W + 3 * REG_W + IMM_W != INSTR_W) begin : g_bad_layout
        $error("decode_stage: field widths do not add up to INSTR_W");
    end
    if (XLEN < IMM_W) begin : g_bad_xlen
        $error("decode_stage: XLEN must be at least IMM_W");
    end

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [XLEN-1:0]     imm;
        logic                illegal;
    } entry_t;

    logic [OPCODE_W-1:0] dec_opcode;
    logic [REG_W-1:0]    dec_rd;
    logic [REG_W-1:0]    dec_rs;
    logic [REG_W-1:0]    dec_rt;
    logic [XLEN-1:0]     dec_imm;
    logic                dec_illegal;
    entry_t              dec_entry;

    entry_t              out_reg;
    entry_t              skid_reg;
    state_t              state_reg;
    state_t              state_next;
    logic                in_ready_reg;
    logic [COUNT_W-1:0]  count_reg;

    logic                accept;
    logic                out_valid;
    logic                out_hs;
    logic                load_out;
    logic                load_skid;
    logic                drain_skid;

    instr_field_split #(
        .INSTR_W    (INSTR_W),
        .OPCODE_W   (OPCODE_W),
        .REG_W      (REG_W),
        .IMM_W      (IMM_W),
        .XLEN       (XLEN),
        .LEGAL_MASK (LEGAL_MASK),
        .ZEXT_MASK  (ZEXT_MASK)
    ) u_split (
        .instr   (bus.in_instr),
        .opcode  (dec_opcode),
        .rd      (dec_rd),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign dec_entry = '{opcode:  dec_opcode,
                         rd:      dec_rd,
                         rs:      dec_rs,
                         rt:      dec_rt,
                         imm:     dec_imm,
                         illegal: dec_illegal};

    assign accept    = bus.in_valid && in_ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_hs    = out_valid && bus.out_ready;

    // Flush wins over every handshake; a simultaneous accept is simply dropped.
    always_comb begin
        state_next = state_reg;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        drain_skid = 1'b0;
        if (bus.flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        load_out   = 1'b1;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && bus.out_ready) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (bus.out_ready) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        drain_skid = 1'b1;
                        state_next = BUSY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // in_ready is the registered image of "next state has a free slot".
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b0;
            out_reg      <= '0;
            skid_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
            if (load_out) begin
                out_reg <= dec_entry;
            end else if (drain_skid) begin
                out_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= dec_entry;
            end
        end
    end

    // Counts output handshakes even in a flush cycle; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (out_hs && (count_reg != {COUNT_W{1'b1}})) begin
            count_reg <= count_reg + COUNT_W'(1);
        end
    end

    assign bus.in_ready     = in_ready_reg;
    assign bus.out_valid    = out_valid;
    assign bus.out_opcode   = out_reg.opcode;
    assign bus.out_rd       = out_reg.rd;
    assign bus.out_rs       = out_reg.rs;
    assign bus.out_rt       = out_reg.rt;
    assign bus.out_imm      = out_reg.imm;
    assign bus.out_illegal  = out_reg.illegal;
    assign bus.decode_count = count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, checked
// against a queue-based model and a field decoder written from the word layout.
module tb_decode_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if #(.COUNT_W(32)) ifc ();
    decode_stage_if #(.COUNT_W(3))  ifc3 ();

    assign ifc3.flush     = ifc.flush;
    assign ifc3.in_valid  = ifc.in_valid;
    assign ifc3.in_instr  = ifc.in_instr;
    assign ifc3.out_ready = ifc.out_ready;

    decode_stage #(.COUNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(ifc));
    decode_stage #(.COUNT_W(3))  dut3 (.clk(clk), .reset(reset), .bus(ifc3));

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q[$];
    int          cnt   = 0;
    bit          mrdy  = 1'b0;

    // Reference decode: opcode low 5 bits, then rd/rs/rt, then a 12-bit immediate.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        e;
        int unsigned i12;
        e.op  = 5'(w % 32);
        e.rd  = 5'((w / 32) % 32);
        e.rs  = 5'((w / 1024) % 32);
        e.rt  = 5'((w / 32768) % 32);
        i12   = w / (2 ** 20);
        if (e.op inside {5'd8, 5'd9, 5'd10, 5'd11}) e.imm = i12;
        else if (i12 >= 2048)                        e.imm = i12 + 32'hFFFF_F000;
        else                                         e.imm = i12;
        e.ill = (e.op >= 5'd30);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        chk("out_valid", 64'(ifc.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(ifc.in_ready), 64'(mrdy));
        if (q.size() > 0) begin
            e = ref_decode(q[0]);
            chk("opcode", 64'(ifc.out_opcode), 64'(e.op));
            chk("rd", 64'(ifc.out_rd), 64'(e.rd));
            chk("rs", 64'(ifc.out_rs), 64'(e.rs));
            chk("rt", 64'(ifc.out_rt), 64'(e.rt));
            chk("imm", 64'(ifc.out_imm), 64'(e.imm));
            chk("illegal", 64'(ifc.out_illegal), 64'(e.ill));
        end
        chk("count", 64'(ifc.decode_count), 64'(cnt));
        chk("count_sat3", 64'(ifc3.decode_count), 64'((cnt > 7) ? 7 : cnt));
    endtask

    // One clock: drive at negedge, update the model at the edge, check at the next negedge.
    task automatic step(input bit v, input logic [31:0] w, input bit ordy,
                        input bit fl, input bit rst);
        bit acc;
        bit hs;
        ifc.in_valid  = v;
        ifc.in_instr  = w;
        ifc.out_ready = ordy;
        ifc.flush     = fl;
        reset         = rst;
        acc = v && mrdy && !rst && !fl;
        hs  = (q.size() > 0) && ordy && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt  = 0;
            mrdy = 1'b0;
        end else begin
            if (hs) cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (hs)  void'(q.pop_front());
                if (acc) q.push_back(w);
            end
            mrdy = (q.size() < 2);
        end
        @(negedge clk);
        $display("step v=%0d instr=%08h ordy=%0d flush=%0d rst=%0d -> out_valid=%0d in_ready=%0d count=%0d",
                 v, w, ordy, fl, rst, ifc.out_valid, ifc.in_ready, ifc.decode_count);
        check_all();
    endtask

    logic [31:0] ws [4];
    int          base;

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_instr  = '0;
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b0;
        reset         = 1'b1;
        ws[0] = 32'h1234_5678; ws[1] = 32'h8000_0A41; ws[2] = 32'h7FF0_0009; ws[3] = 32'hDEAD_BEE2;

        // Reset state
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("rst_opcode", 64'(ifc.out_opcode), 64'd0);
        chk("rst_imm", 64'(ifc.out_imm), 64'd0);
        chk("rst_rd_rs_rt", 64'({ifc.out_rd, ifc.out_rs, ifc.out_rt}), 64'd0);
        chk("rst_illegal", 64'(ifc.out_illegal), 64'd0);
        step(0, '0, 0, 0, 0);
        chk("rdy_after_reset", 64'(ifc.in_ready), 64'd1);

        // Basic decode, sign extension, zero extension, illegal opcode
        step(1, 32'hFFF2_0823, 1, 0, 0);
        chk("t1_valid", 64'(ifc.out_valid), 64'd1);
        chk("t1_opcode", 64'(ifc.out_opcode), 64'd3);
        chk("t1_rd", 64'(ifc.out_rd), 64'd1);
        chk("t1_rs", 64'(ifc.out_rs), 64'd2);
        chk("t1_rt", 64'(ifc.out_rt), 64'd4);
        chk("t1_imm", 64'(ifc.out_imm), 64'hFFFF_FFFF);
        chk("t1_illegal", 64'(ifc.out_illegal), 64'd0);
        step(1, 32'hFFF2_0828, 1, 0, 0);
        chk("t1_count", 64'(ifc.decode_count), 64'd1);
        chk("zext_imm", 64'(ifc.out_imm), 64'h0000_0FFF);
        step(1, 32'h0000_001F, 1, 0, 0);
        chk("illegal_flag", 64'(ifc.out_illegal), 64'd1);
        step(0, '0, 1, 0, 0);
        chk("count_3", 64'(ifc.decode_count), 64'd3);

        // Stall with out_ready low: fills SKID, then drains in order
        step(1, ws[0], 0, 0, 0);
        step(1, ws[1], 0, 0, 0);
        chk("full_in_ready", 64'(ifc.in_ready), 64'd0);
        step(1, ws[2], 0, 0, 0);
        step(1, ws[2], 1, 0, 0);
        step(1, ws[2], 1, 0, 0);
        step(1, ws[3], 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("stream_count", 64'(ifc.decode_count), 64'd7);

        // Flush while FULL with an offered input
        step(1, 32'h0000_0101, 0, 0, 0);
        step(1, 32'h0000_0202, 0, 0, 0);
        step(1, 32'h0000_0303, 0, 1, 0);
        chk("flush_valid", 64'(ifc.out_valid), 64'd0);
        chk("flush_ready", 64'(ifc.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
        chk("flush_nothing_left", 64'(ifc.out_valid), 64'd0);

        // A handshake in the flush cycle is still counted
        base = cnt;
        step(1, 32'h0000_0404, 1, 0, 0);
        step(0, '0, 1, 1, 0);
        chk("flush_hs_count", 64'(ifc.decode_count), 64'(base + 1));

        // Reset mid-stream while BUSY
        step(1, 32'h0000_0505, 0, 0, 0);
        step(1, 32'h0000_0606, 1, 0, 1);
        chk("midrst_valid", 64'(ifc.out_valid), 64'd0);
        chk("midrst_count", 64'(ifc.decode_count), 64'd0);
        step(0, '0, 1, 0, 0);
        chk("midrst_ready", 64'(ifc.in_ready), 64'd1);

        // Nine handshakes: the 3-bit counter saturates at 7
        for (int i = 0; i < 10; i++) step(1, 32'(i * 32'h0101_0101), 1, 0, 0);
        chk("sat3_count", 64'(ifc3.decode_count), 64'd7);
        chk("wide_count", 64'(ifc.decode_count), 64'd9);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
